philv_ctrl_fsm: RTL and testbench

Multi-cycle control state machine for the PhilosophyV core. It sequences fetch, decode, execute, memory and writeback for the shared ALU, register file and unified memory port. It drives the instruction decoder's `controlOverride` so the ALU performs ADD for PC arithmetic and address arithmetic. It also keeps a retired-instruction counter and halts on unsupported opcodes.

---
 rtl/philv_ctrl_fsm.sv | 198 +++++++++++++++++++
 tb/tb_philv_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/philv_ctrl_fsm.sv
// Multi-cycle control FSM for the PhilosophyV core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU, register file and unified memory port, and counts retired instructions.
module philv_ctrl_fsm #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic         br_eq_i,
  input  logic         br_lt_i,
  input  logic         mem_ready_i,
  output logic         controlOverride_o,
  output logic         ir_we_o,
  output logic         oldpc_we_o,
  output logic         pc_we_o,
  output logic         aluout_we_o,
  output logic         rf_we_o,
  output logic [1:0]   pc_src_o,
  output logic [1:0]   alu_a_sel_o,
  output logic [1:0]   alu_b_sel_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic         mem_addr_sel_o,
  output logic [1:0]   wb_sel_o,
  output logic         halted_o,
  output logic [N-1:0] instret_o,
  output logic [3:0]   state_o
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEM     = 4'd4,
    S_WB      = 4'd5,
    S_BRTGT   = 4'd6,
    S_JUMP    = 4'd7,
    S_HALT    = 4'd8
  } state_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_e         state_q, state_d;
  logic [N-1:0]   instret_q, instret_d;
  logic           legal_s;
  logic           retire_s;

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

  assign legal_s = (opcode_i == OP_REG)   || (opcode_i == OP_IMM)    ||
                   (opcode_i == OP_LOAD)  || (opcode_i == OP_STORE)  ||
                   (opcode_i == OP_BRANCH)|| (opcode_i == OP_JAL)    ||
                   (opcode_i == OP_JALR);

  // State and retired-instruction counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic and retirement detection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = legal_s ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        case (opcode_i)
          OP_REG, OP_IMM:    state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH:         state_d = branch_taken(funct3_i, br_eq_i, br_lt_i) ? S_BRTGT : S_FETCH;
          OP_JAL, OP_JALR:   state_d = S_JUMP;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i) begin
          state_d = (opcode_i == OP_LOAD) ? S_WB : S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB, S_BRTGT, S_JUMP: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
    // An instruction retires whenever control returns to FETCH, except the first FETCH after reset
    retire_s  = (state_q != S_RESET) && (state_q != S_FETCH) && (state_d == S_FETCH);
    instret_d = retire_s ? (instret_q + N'(1)) : instret_q;
  end

  // Output decode from current state
  always_comb begin
    controlOverride_o = 1'b0;
    ir_we_o           = 1'b0;
    oldpc_we_o        = 1'b0;
    pc_we_o           = 1'b0;
    aluout_we_o       = 1'b0;
    rf_we_o           = 1'b0;
    pc_src_o          = 2'd0;
    alu_a_sel_o       = 2'd0;
    alu_b_sel_o       = 2'd0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_addr_sel_o    = 1'b0;
    wb_sel_o          = 2'd0;
    halted_o          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o         = 1'b1;
        alu_b_sel_o       = 2'd2;
        controlOverride_o = 1'b1;
        ir_we_o           = mem_ready_i;
        oldpc_we_o        = mem_ready_i;
        pc_we_o           = mem_ready_i;
      end
      S_EXECUTE: begin
        case (opcode_i)
          OP_REG: begin
            alu_a_sel_o = 2'd2;
            aluout_we_o = 1'b1;
          end
          OP_IMM: begin
            alu_a_sel_o = 2'd2;
            alu_b_sel_o = 2'd1;
            aluout_we_o = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            alu_a_sel_o       = 2'd2;
            alu_b_sel_o       = 2'd1;
            controlOverride_o = 1'b1;
            aluout_we_o       = 1'b1;
          end
          OP_BRANCH: alu_a_sel_o = 2'd2;
          OP_JAL: begin
            alu_a_sel_o       = 2'd1;
            alu_b_sel_o       = 2'd1;
            controlOverride_o = 1'b1;
            aluout_we_o       = 1'b1;
          end
          default: alu_a_sel_o = 2'd0;
        endcase
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (opcode_i == OP_STORE);
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (opcode_i == OP_LOAD) ? 2'd1 : 2'd0;
      end
      S_BRTGT: begin
        alu_a_sel_o       = 2'd1;
        alu_b_sel_o       = 2'd1;
        controlOverride_o = 1'b1;
        pc_we_o           = 1'b1;
      end
      // The link value is the PC, which already holds OLDPC+4 from FETCH
      S_JUMP: begin
        rf_we_o  = 1'b1;
        wb_sel_o = 2'd2;
        pc_we_o  = 1'b1;
        pc_src_o = (opcode_i == OP_JAL) ? 2'd1 : 2'd2;
      end
      S_HALT:  halted_o = 1'b1;
      default: halted_o = 1'b0;
    endcase
  end

  assign instret_o = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_philv_ctrl_fsm.sv
// Directed bench for philv_ctrl_fsm: builds the expected per-cycle output trace of each instruction
// class from its phase list and compares it with the DUT every cycle.
module tb_philv_ctrl_fsm;

  localparam int NW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, br_eq_i, br_lt_i, mem_ready_i;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic          controlOverride_o, ir_we_o, oldpc_we_o, pc_we_o, aluout_we_o, rf_we_o;
  logic [1:0]    pc_src_o, alu_a_sel_o, alu_b_sel_o, wb_sel_o;
  logic          mem_req_o, mem_we_o, mem_addr_sel_o, halted_o;
  logic [NW-1:0] instret_o;
  logic [3:0]    state_o;

  philv_ctrl_fsm #(.N(NW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .mem_ready_i(mem_ready_i),
    .controlOverride_o(controlOverride_o), .ir_we_o(ir_we_o), .oldpc_we_o(oldpc_we_o),
    .pc_we_o(pc_we_o), .aluout_we_o(aluout_we_o), .rf_we_o(rf_we_o), .pc_src_o(pc_src_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o), .wb_sel_o(wb_sel_o),
    .halted_o(halted_o), .instret_o(instret_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]    st;
    logic          co, irw, opw, pcw, aw, rfw;
    logic [1:0]    pcs, as, bs;
    logic          mr, mw, mas;
    logic [1:0]    wbs;
    logic          h;
    logic [NW-1:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  int   cyc;

  function automatic rec_t base(input logic [3:0] st);
    rec_t r;
    r     = '0;
    r.st  = st;
    r.cnt = model_cnt[NW-1:0];
    return r;
  endfunction

  // Single compare process: one expected record per cycle while the queue is fed
  always @(negedge clk_i) begin
    rec_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state_o, controlOverride_o, ir_we_o, oldpc_we_o, pc_we_o, aluout_we_o, rf_we_o,
           pc_src_o, alu_a_sel_o, alu_b_sel_o, mem_req_o, mem_we_o, mem_addr_sel_o,
           wb_sel_o, halted_o, instret_o};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t state=%0d got=%h exp=%h", $time, e.st, a, e);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input rec_t r, input logic mr);
    mem_ready_i = mr;
    exp_q.push_back(r);
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // cur_valid: check the cycle in which rst is raised against 'cur'
  task automatic do_reset(input logic cur_valid, input rec_t cur, input logic mr);
    rst_i = 1'b1;
    if (cur_valid) step(cur, mr);
    model_cnt = 0;
    step(base(4'd0), 1'b1);
    rst_i = 1'b0;
    step(base(4'd0), 1'b1);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                           input logic lt, input int fw, input int mwait);
    rec_t r;
    logic taken;
    logic is_jal;
    opcode_i = op; funct3_i = f3; br_eq_i = eq; br_lt_i = lt;
    cyc = 0;
    r = base(4'd1); r.mr = 1'b1; r.bs = 2'd2; r.co = 1'b1;
    for (int i = 0; i < fw; i++) step(r, 1'b0);
    r.irw = 1'b1; r.opw = 1'b1; r.pcw = 1'b1;
    step(r, 1'b1);
    step(base(4'd2), rnd());
    if (!(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                     7'b1100011, 7'b1101111, 7'b1100111})) return;
    r = base(4'd3);
    case (op)
      7'b0110011, 7'b0010011: begin
        r.as = 2'd2; r.bs = (op == 7'b0010011) ? 2'd1 : 2'd0; r.aw = 1'b1;
        step(r, rnd());
        r = base(4'd5); r.rfw = 1'b1;
        step(r, rnd());
      end
      7'b0000011, 7'b0100011: begin
        r.as = 2'd2; r.bs = 2'd1; r.co = 1'b1; r.aw = 1'b1;
        step(r, rnd());
        r = base(4'd4); r.mr = 1'b1; r.mas = 1'b1; r.mw = (op == 7'b0100011);
        for (int i = 0; i < mwait; i++) step(r, 1'b0);
        step(r, 1'b1);
        if (op == 7'b0000011) begin
          r = base(4'd5); r.rfw = 1'b1; r.wbs = 2'd1;
          step(r, rnd());
        end
      end
      7'b1100011: begin
        // Pairs of funct3 share a condition; the low bit inverts it
        case (f3[2:1])
          2'b00:   taken = eq ^ f3[0];
          2'b01:   taken = 1'b0;
          default: taken = lt ^ f3[0];
        endcase
        r.as = 2'd2;
        step(r, rnd());
        if (taken) begin
          r = base(4'd6); r.as = 2'd1; r.bs = 2'd1; r.co = 1'b1; r.pcw = 1'b1;
          step(r, rnd());
        end
      end
      default: begin
        is_jal = (op == 7'b1101111);
        r.as = is_jal ? 2'd1 : 2'd2; r.bs = 2'd1; r.co = 1'b1; r.aw = 1'b1;
        step(r, rnd());
        r = base(4'd7); r.rfw = 1'b1; r.wbs = 2'd2; r.pcw = 1'b1;
        r.pcs = is_jal ? 2'd1 : 2'd2;
        step(r, rnd());
      end
    endcase
    model_cnt = (model_cnt + 1) % (1 << NW);
  endtask

  initial begin
    rec_t r;
    rst_i = 1'b1; mem_ready_i = 1'b1; opcode_i = 7'd0; funct3_i = 3'd0;
    br_eq_i = 1'b0; br_lt_i = 1'b0;
    @(posedge clk_i); #1;
    do_reset(1'b0, base(4'd0), 1'b1);
    chk("post_reset_state", int'(state_o), 1);

    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);   // ADDI
    chk("addi_latency", cyc, 4);
    chk("addi_instret", int'(instret_o), 1);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1, 0);   // ADD, one fetch wait
    chk("add_latency", cyc, 5);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);   // LW, 3 MEM waits
    chk("lw_latency", cyc, 8);
    chk("lw_instret", int'(instret_o), 3);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);   // SW
    chk("sw_latency", cyc, 5);
    run_instr(7'b1100011, 3'b001, 1'b1, 1'b0, 0, 0);   // BNE not taken
    chk("bne_nt_latency", cyc, 3);
    run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, 0, 0);   // BEQ taken
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0);   // BLT taken
    chk("blt_t_latency", cyc, 4);
    run_instr(7'b1100011, 3'b111, 1'b0, 1'b1, 0, 0);   // BGEU not taken
    run_instr(7'b1100011, 3'b010, 1'b1, 1'b1, 0, 0);   // funct3 010 never taken
    run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 0, 0);   // BGE taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // JAL
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0);   // JALR
    chk("jalr_latency", cyc, 4);
    chk("instret_before_lui", int'(instret_o), 12);

    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);   // LUI halts after DECODE
    r = base(4'd8); r.h = 1'b1;
    for (int i = 0; i < 10; i++) step(r, rnd());
    chk("halt_sticky", int'(halted_o), 1);
    do_reset(1'b1, r, 1'b1);

    // Reset during a MEM wait aborts the access
    opcode_i = 7'b0000011; funct3_i = 3'b010;
    r = base(4'd1); r.mr = 1'b1; r.bs = 2'd2; r.co = 1'b1; r.irw = 1'b1; r.opw = 1'b1; r.pcw = 1'b1;
    step(r, 1'b1);
    step(base(4'd2), 1'b1);
    r = base(4'd3); r.as = 2'd2; r.bs = 2'd1; r.co = 1'b1; r.aw = 1'b1;
    step(r, 1'b1);
    r = base(4'd4); r.mr = 1'b1; r.mas = 1'b1;
    step(r, 1'b0);
    do_reset(1'b1, r, 1'b0);
    chk("abort_instret", int'(instret_o), 0);

    for (int i = 0; i < 15; i++) run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("instret_all_ones", int'(instret_o), 15);
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("instret_wrap", int'(instret_o), 0);

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
